// File: rtl/ulpi_reg_seq.sv
// ulpi_reg_seq: ULPI link-side register-access sequencer.
// Turns single read/write requests into ULPI TX-CMD register transactions.
// Optional build macro ULPI_REG_SEQ_BOOT_EN adds a post-reset boot sequence
// (Function Control, then OTG Control) that puts the PHY into sniff mode.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | bus NOOP, accepting requests (or launching boot writes)
// S_CMD     | driving TX CMD byte, waiting for nxt
// S_WAIT_RX | PHY took the bus (RX CMD); wait for turnaround, then replay
// S_WDATA   | driving write data, waiting for nxt
// S_STP     | one-cycle stp (end of write, or timeout abort)
// S_RD_TURN | read: waiting for PHY to raise dir
// S_RD_DATA | read: capturing data while dir=1, done when dir drops
// S_DONE    | one-cycle response
module ulpi_reg_seq #(
  parameter int unsigned TIMEOUT_W      = 8,
  parameter logic [7:0]  BOOT_FUNC_CTRL = 8'h48,
  parameter logic [7:0]  BOOT_OTG_CTRL  = 8'h06
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  input  logic       req_write_i,
  input  logic [5:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       req_ready_o,
  output logic       resp_valid_o,
  output logic [7:0] resp_rdata_o,
  output logic       resp_err_o,
  output logic       boot_done_o,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  output logic       ulpi_stp_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WAIT_RX, S_WDATA, S_STP, S_RD_TURN, S_RD_DATA, S_DONE
  } state_t;

  // Timeout fires on the wait cycle where the counter would reach 2**W-1.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] CNT_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 write_q, write_d;
  logic [5:0]           addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 boot_done_q, boot_done_d;
  logic                 cnt_last;
`ifdef ULPI_REG_SEQ_BOOT_EN
  logic                 boot_txn_q, boot_txn_d;
  logic                 boot_step_q, boot_step_d;
`endif

  assign cnt_last     = (cnt_q == CNT_LAST);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign boot_done_o  = boot_done_q;

  // Next-state, datapath updates and bus outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
`ifdef ULPI_REG_SEQ_BOOT_EN
    boot_done_d  = boot_done_q;
    boot_txn_d   = boot_txn_q;
    boot_step_d  = boot_step_q;
`else
    boot_done_d  = 1'b1;
`endif
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    ulpi_data_o  = 8'h00;
    ulpi_stp_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
`ifdef ULPI_REG_SEQ_BOOT_EN
        if (!boot_done_q) begin
          if (!ulpi_dir_i) begin
            write_d    = 1'b1;
            addr_d     = boot_step_q ? 6'h0A : 6'h04;
            wdata_d    = boot_step_q ? BOOT_OTG_CTRL : BOOT_FUNC_CTRL;
            rdata_d    = 8'h00;
            err_d      = 1'b0;
            cnt_d      = '0;
            boot_txn_d = 1'b1;
            state_d    = S_CMD;
          end
        end else
`endif
        if (boot_done_q && !ulpi_dir_i) begin
          req_ready_o = 1'b1;
          if (req_valid_i) begin
            write_d = req_write_i;
            addr_d  = req_addr_i;
            wdata_d = req_wdata_i;
            rdata_d = 8'h00;
            err_d   = 1'b0;
            cnt_d   = '0;
`ifdef ULPI_REG_SEQ_BOOT_EN
            boot_txn_d = 1'b0;
`endif
            state_d = S_CMD;
          end
        end
      end
      S_CMD: begin
        ulpi_data_o = {write_q ? 2'b10 : 2'b11, addr_q};
        if (ulpi_dir_i) begin
          state_d = S_WAIT_RX;
        end else if (ulpi_nxt_i) begin
          cnt_d   = '0;
          state_d = write_q ? S_WDATA : S_RD_TURN;
        end else if (cnt_last) begin
          err_d   = 1'b1;
          state_d = S_STP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_RX: begin
        if (!ulpi_dir_i) begin
          cnt_d   = '0;
          state_d = S_CMD;
        end
      end
      S_WDATA: begin
        ulpi_data_o = wdata_q;
        if (ulpi_nxt_i) begin
          state_d = S_STP;
        end else if (cnt_last) begin
          err_d   = 1'b1;
          state_d = S_STP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STP: begin
        ulpi_stp_o = 1'b1;
        state_d    = S_DONE;
      end
      S_RD_TURN: begin
        if (ulpi_dir_i) begin
          state_d = ulpi_nxt_i ? S_WAIT_RX : S_RD_DATA;
        end else if (cnt_last) begin
          err_d   = 1'b1;
          state_d = S_STP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RD_DATA: begin
        if (ulpi_dir_i) rdata_d = ulpi_data_i;
        else            state_d = S_DONE;
      end
      S_DONE: begin
`ifdef ULPI_REG_SEQ_BOOT_EN
        resp_valid_o = ~boot_txn_q;
        // A timed-out boot write is simply relaunched from IDLE.
        if (boot_txn_q && !err_q) begin
          boot_step_d = 1'b1;
          if (boot_step_q) boot_done_d = 1'b1;
        end
        boot_txn_d = 1'b0;
`else
        resp_valid_o = 1'b1;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= 6'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      err_q       <= 1'b0;
      boot_done_q <= 1'b0;
`ifdef ULPI_REG_SEQ_BOOT_EN
      boot_txn_q  <= 1'b0;
      boot_step_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      boot_done_q <= boot_done_d;
`ifdef ULPI_REG_SEQ_BOOT_EN
      boot_txn_q  <= boot_txn_d;
      boot_step_q <= boot_step_d;
`endif
    end
  end

endmodule
